// File: rtl/t_counter_pkg.sv
// Shared constants for the T flip-flop based modulo counter.
package t_counter_pkg;

    localparam int T_DEFAULT_WIDTH = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/t_ff.sv
// Single-bit toggle flip-flop with asynchronous active-low reset.
module t_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/t_mod_counter.sv
// Up/down modulo-(MAX+1) counter built from T flip-flops, with parallel load.
// Define T_COUNTER_SATURATE_EN to hold at the end value instead of wrapping.
module t_mod_counter
    import t_counter_pkg::*;
#(
    parameter int               WIDTH = T_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             T,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    logic             at_end;
    logic             wrap_next;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] toggle;

    assign at_end = (Up == DIR_UP) ? (Q == MAX) : (Q == '0);
    assign TC     = T & at_end;

    // All next values, including load and the modulus wrap, funnel through next_q.
    always_comb begin
        next_q    = Q;
        wrap_next = 1'b0;
        if (Load) begin
            next_q = (D > MAX) ? MAX : D;
        end else if (T) begin
            if (at_end) begin
`ifdef T_COUNTER_SATURATE_EN
                next_q = Q;
`else
                next_q    = (Up == DIR_UP) ? '0 : MAX;
                wrap_next = 1'b1;
`endif
            end else begin
                next_q = (Up == DIR_DOWN) ? Q - 1'b1 : Q + 1'b1;
            end
        end
    end

    assign toggle = next_q ^ Q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff u_bit (
            .clk  (CLK),
            .rst_n(Reset),
            .t    (toggle[i]),
            .q    (Q[i])
        );
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            Wrap <= 1'b0;
        else
            Wrap <= wrap_next;
    end

endmodule

// File: tb/tb_t_mod_counter.sv
// Directed self-checking bench: an 8-bit full-range counter and a 4-bit modulo-10 counter.
module tb_t_mod_counter;

`ifdef T_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       t8, up8, load8;
    logic [7:0] d8, q8;
    logic       tc8, wrap8;
    logic       t9, up9, load9;
    logic [3:0] d9, q9;
    logic       tc9, wrap9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t_mod_counter #(.WIDTH(8)) dut8 (
        .CLK(clk), .Reset(reset), .T(t8), .Up(up8), .Load(load8),
        .D(d8), .Q(q8), .TC(tc8), .Wrap(wrap8)
    );

    t_mod_counter #(.WIDTH(4), .MAX(4'd9)) dut9 (
        .CLK(clk), .Reset(reset), .T(t9), .Up(up9), .Load(load9),
        .D(d9), .Q(q9), .TC(tc9), .Wrap(wrap9)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] down_q [5];
        logic       down_w [5];
        down_q = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        down_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        t8 = 1'b0; up8 = 1'b1; load8 = 1'b0; d8 = '0;
        t9 = 1'b0; up9 = 1'b1; load9 = 1'b0; d9 = '0;

        // Held in reset with T=1: nothing moves.
        @(negedge clk);
        t8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_q", 32'(q8), 32'd0);
            check("rst_wrap", 32'(wrap8), 32'd0);
        end
        check("rst_q9", 32'(q9), 32'd0);

        reset = 1'b1;
        t8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_q", 32'(q8), 32'd0);
        end

        // Full up-count sweep 0..255 and the wrap back to 0.
        t8 = 1'b1; up8 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            check("up_q", 32'(q8), 32'(i));
            check("up_tc", 32'(tc8), 32'(i == 255));
            check("up_wrap", 32'(wrap8), 32'd0);
            @(negedge clk);
        end
        check("wrap_q", 32'(q8), SAT ? 32'hFF : 32'h00);
        check("wrap_pulse", 32'(wrap8), SAT ? 32'd0 : 32'd1);
        t8 = 1'b0;
        @(negedge clk);
        check("wrap_clear", 32'(wrap8), 32'd0);

        // Load beats T in the same cycle.
        load8 = 1'b1; d8 = 8'h10;
        @(negedge clk);
        check("load_10", 32'(q8), 32'h10);
        t8 = 1'b1; d8 = 8'h5A;
        @(negedge clk);
        check("load_pri", 32'(q8), 32'h5A);
        check("load_wrap", 32'(wrap8), 32'd0);
        load8 = 1'b0; up8 = 1'b0;
        @(negedge clk);
        check("dir_down", 32'(q8), 32'h59);
        up8 = 1'b1;
        @(negedge clk);
        check("dir_up", 32'(q8), 32'h5A);
        t8 = 1'b0;

        // Asynchronous reset between edges.
        load8 = 1'b1; d8 = 8'h7F;
        @(negedge clk);
        check("load_7f", 32'(q8), 32'h7F);
        load8 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_q", 32'(q8), 32'd0);
        check("async_wrap", 32'(wrap8), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Down-count from 0 wraps to 255.
        t8 = 1'b1; up8 = 1'b0;
        #1;
        check("down_tc", 32'(tc8), 32'd1);
        @(negedge clk);
        check("down_wrap_q", 32'(q8), SAT ? 32'h00 : 32'hFF);
        check("down_wrap_pulse", 32'(wrap8), SAT ? 32'd0 : 32'd1);
        t8 = 1'b0;
        @(negedge clk);
        check("down_hold", 32'(wrap8), 32'd0);

        // Modulo-10 counter: 3,2,1,0,9,8.
        load9 = 1'b1; d9 = 4'd3;
        @(negedge clk);
        check("m9_load", 32'(q9), 32'd3);
        load9 = 1'b0; t9 = 1'b1; up9 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("m9_q", 32'(q9), (SAT && k > 2) ? 32'd0 : 32'(down_q[k]));
            check("m9_wrap", 32'(wrap9), SAT ? 32'd0 : 32'(down_w[k]));
            if (k == 2) check("m9_tc0", 32'(tc9), 32'd1);
        end
        load9 = 1'b1; d9 = 4'd12;
        @(negedge clk);
        check("m9_clamp", 32'(q9), 32'd9);
        load9 = 1'b0; up9 = 1'b1;
        #1;
        check("m9_tc9", 32'(tc9), 32'd1);
        @(negedge clk);
        check("m9_upwrap_q", 32'(q9), SAT ? 32'd9 : 32'd0);
        check("m9_upwrap_w", 32'(wrap9), SAT ? 32'd0 : 32'd1);
        t9 = 1'b0;

`ifdef T_COUNTER_SATURATE_EN
        load8 = 1'b1; d8 = 8'hFF;
        @(negedge clk);
        load8 = 1'b0; t8 = 1'b1; up8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sat_q", 32'(q8), 32'hFF);
            check("sat_wrap", 32'(wrap8), 32'd0);
            check("sat_tc", 32'(tc8), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_mod_counter.md
T_MOD_COUNTER -- requirements
Module: t_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1, highest count value, legal range 1..2**WIDTH-1.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 T  input  1  count enable; when 1, counter steps one value per clock.
REQ-006 Up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Load  input  1  synchronous parallel load strobe.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 TC  output  1  combinational terminal count: T & (Up ? Q==MAX : Q==0).
REQ-011 Wrap  output  1  registered one-cycle pulse, set in the cycle after Q wraps.

Function
REQ-012 Priority per clock SHALL be Load > T > hold.
REQ-013 Load=1: Q SHALL take D next cycle, clamped to MAX when D > MAX; Wrap SHALL be 0.
REQ-014 Load=0, T=1, Up=1, Q<MAX: Q SHALL become Q+1.
REQ-015 Load=0, T=1, Up=1, Q==MAX: Q SHALL become 0 and Wrap SHALL be 1 next cycle.
REQ-016 Load=0, T=1, Up=0, Q>0: Q SHALL become Q-1.
REQ-017 Load=0, T=1, Up=0, Q==0: Q SHALL become MAX and Wrap SHALL be 1 next cycle.
REQ-018 Load=0, T=0: Q SHALL hold; Wrap SHALL be 0 next cycle.
REQ-019 Latency from T/Load/D sample to Q update SHALL be one clock.
REQ-020 Up change takes effect on the same edge it is sampled; no direction-change penalty.
REQ-021 Q SHALL never exceed MAX in any reachable state.
REQ-022 TC SHALL be usable as T of a cascaded next-stage counter without extra glue.

Reset
REQ-023 Reset=0 SHALL force Q=0 and Wrap=0 immediately, independent of CLK.
REQ-024 Reset asserted mid-count SHALL discard any pending load or step.
REQ-025 First count step after Reset release SHALL occur on the first rising edge with Reset=1 and T=1.

Configuration
REQ-026 Macro T_COUNTER_SATURATE_EN SHALL select saturating mode.
REQ-027 With T_COUNTER_SATURATE_EN defined: at Q==MAX with Up=1, or Q==0 with Up=0, Q SHALL hold and Wrap SHALL stay 0; TC unchanged.
REQ-028 Without T_COUNTER_SATURATE_EN: wrap behaviour of REQ-015/REQ-017 applies.

Structure
REQ-029 Package t_counter_pkg SHALL hold the default WIDTH constant and the UP/DOWN direction encoding constants.
REQ-030 Sub-module t_ff (1-bit T flip-flop, async active-low reset) SHALL be instantiated WIDTH times for Q.
REQ-031 Per-bit toggle enable SHALL be computed as next_Q XOR Q from the next-value logic; load and modulus use the same path.

Verification (WIDTH=8 unless stated)
REQ-032 Reset=0, T=1 for 8 clocks -> Q=0, Wrap=0 throughout; release Reset, T=0 for 8 clocks -> Q holds 0.
REQ-033 Reset=1, T=1, Up=1 for 256 clocks from 0 -> Q steps 0..255 then 0; Wrap=1 exactly one cycle after 255->0; TC=1 only while Q=255.
REQ-034 MAX=9, Up=0 from Load D=3 -> Q=3,2,1,0,9,8; Wrap pulse after 0->9; Load D=12 -> Q=9.
REQ-035 Load=1 and T=1 same cycle with D=0x5A, Q=0x10 -> Q=0x5A next cycle, no step.
REQ-036 Reset=0 asserted between clock edges at Q=0x7F -> Q=0 immediately, before next edge.
REQ-037 T_COUNTER_SATURATE_EN defined, Up=1, Q=255, T=1 for 4 clocks -> Q stays 255, Wrap=0, TC=1.
